// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: soft-start / soft-stop stage in front of the PWM generator.
// Forwards period and high-time to the generator. The high-time slews toward
// its target by a programmable step once per PWM period. Every change lands
// on a period boundary, so the generator never sees a mid-period glitch.
//
// Build option: define PWM_DUTY_RAMP_DIV_EN to add the ramp_div input. That
// input makes the slew steps happen only on every 2^ramp_div-th period end.
module pwm_duty_ramp #(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_in,
  input  logic [WIDTH-1:0]  cycles_high_tgt,
  input  logic [WIDTH-1:0]  cycles_freq_tgt,
  input  logic [STEP_W-1:0] step,
`ifdef PWM_DUTY_RAMP_DIV_EN
  input  logic [3:0]        ramp_div,
`endif
  output logic              start_out,
  output logic [WIDTH-1:0]  cycles_high_out,
  output logic [WIDTH-1:0]  cycles_freq_out,
  output logic              ramp_done,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RAMP_UP   = 2'd1,
    S_TRACK     = 2'd2,
    S_RAMP_DOWN = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_start;
  logic [WIDTH-1:0]  r_high;
  logic [WIDTH-1:0]  r_freq;
  logic [WIDTH-1:0]  r_cnt;
  logic              r_done;

  // Effective target: the high-time can never exceed the period.
  logic [WIDTH-1:0]  w_tgt;
  // Slew arithmetic carries one extra bit so sums and borrows are visible.
  logic [WIDTH:0]    w_cur_x;
  logic [WIDTH:0]    w_step_x;
  logic [WIDTH:0]    w_tgt_x;
  logic [WIDTH:0]    w_sum_x;
  logic [WIDTH:0]    w_diff_x;
  logic [WIDTH:0]    w_floor_x;
  logic [WIDTH-1:0]  w_up;
  logic [WIDTH-1:0]  w_dn;
  logic [WIDTH-1:0]  w_toward;
  logic [WIDTH-1:0]  w_to_zero;
  logic              w_step_zero;
  logic              w_period_end;
  logic              w_slew_en;

  assign w_tgt       = (cycles_high_tgt < cycles_freq_tgt) ? cycles_high_tgt : cycles_freq_tgt;
  assign w_cur_x     = {1'b0, r_high};
  assign w_step_x    = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  assign w_tgt_x     = {1'b0, w_tgt};
  assign w_sum_x     = w_cur_x + w_step_x;
  assign w_diff_x    = w_cur_x - w_step_x;
  assign w_floor_x   = w_tgt_x + w_step_x;
  assign w_step_zero = (step == '0);

  // Up: min(cur+step, tgt). A zero step jumps straight to the target.
  assign w_up = (w_step_zero || (w_sum_x > w_tgt_x)) ? w_tgt : w_sum_x[WIDTH-1:0];
  // Down toward target: cur-step, never below tgt (cur-step < tgt <=> cur < tgt+step).
  assign w_dn = (w_step_zero || (w_cur_x < w_floor_x)) ? w_tgt : w_diff_x[WIDTH-1:0];
  // Tracking moves in whichever direction closes the gap.
  assign w_toward = (r_high < w_tgt) ? w_up :
                    (r_high > w_tgt) ? w_dn : r_high;
  // Soft-stop: cur-step saturated at zero; the top bit of the difference is the borrow.
  assign w_to_zero = (w_step_zero || w_diff_x[WIDTH]) ? '0 : w_diff_x[WIDTH-1:0];

  // A period of 0 or 1 clocks ends on every cycle.
  assign w_period_end = (r_freq < WIDTH'(2)) || (r_cnt == (r_freq - WIDTH'(1)));

`ifdef PWM_DUTY_RAMP_DIV_EN
  logic [15:0] r_pdiv;
  logic [15:0] w_div_mask;
  logic        w_ramp_entry;

  assign w_div_mask   = (16'd1 << ramp_div) - 16'd1;
  assign w_slew_en    = w_period_end && (r_pdiv == w_div_mask);
  assign w_ramp_entry = ((r_state == S_IDLE)      &&  start_in) ||
                        ((r_state == S_RAMP_UP)   && !start_in) ||
                        ((r_state == S_TRACK)     && !start_in) ||
                        ((r_state == S_RAMP_DOWN) &&  start_in);

  // Period-end prescaler: restarts whenever a ramp phase is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pdiv <= '0;
    end else if (w_ramp_entry) begin
      r_pdiv <= '0;
    end else if (w_period_end && r_start) begin
      r_pdiv <= w_slew_en ? 16'd0 : r_pdiv + 16'd1;
    end
  end
`else
  assign w_slew_en = w_period_end;
`endif

  // Ramp controller: period counter, slew updates and state transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_start <= 1'b0;
      r_high  <= '0;
      r_freq  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_start) begin
        r_cnt <= w_period_end ? '0 : r_cnt + WIDTH'(1);
      end
      unique case (r_state)
        S_IDLE: begin
          if (start_in) begin
            r_freq  <= cycles_freq_tgt;
            r_high  <= '0;
            r_start <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_RAMP_UP;
          end
        end
        S_RAMP_UP: begin
          if (w_slew_en) begin
            r_high <= w_up;
            if (w_up == w_tgt) begin
              r_done  <= 1'b1;
              r_state <= S_TRACK;
            end
          end
          // Losing the run request overrides any completion on this cycle.
          if (!start_in) begin
            r_state <= S_RAMP_DOWN;
          end
        end
        S_TRACK: begin
          if (w_period_end) begin
            r_freq <= cycles_freq_tgt;
          end
          if (w_slew_en) begin
            r_high <= w_toward;
            if ((w_toward == w_tgt) && (r_high != w_tgt)) begin
              r_done <= 1'b1;
            end
          end
          if (!start_in) begin
            r_state <= S_RAMP_DOWN;
          end
        end
        S_RAMP_DOWN: begin
          if (w_slew_en) begin
            r_high <= w_to_zero;
            if (w_to_zero == '0) begin
              r_start <= 1'b0;
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end
          end
          // Re-request resumes ramping up from the current high-time.
          if (start_in) begin
            r_start <= 1'b1;
            r_state <= S_RAMP_UP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign start_out       = r_start;
  assign cycles_high_out = r_high;
  assign cycles_freq_out = r_freq;
  assign ramp_done       = r_done;
  assign busy            = (r_state != S_IDLE);

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Bench for pwm_duty_ramp. A reference model of the period-boundary rules
// predicts every change of the output tuple. The predictions go into a
// scoreboard queue, and a monitor compares them against the DUT as the
// outputs change.
module tb_pwm_duty_ramp;

  localparam int WIDTH  = 16;
  localparam int STEP_W = 8;

  logic              clk;
  logic              rst_n;
  logic              start_in;
  logic [WIDTH-1:0]  cycles_high_tgt;
  logic [WIDTH-1:0]  cycles_freq_tgt;
  logic [STEP_W-1:0] step;
  logic              start_out;
  logic [WIDTH-1:0]  cycles_high_out;
  logic [WIDTH-1:0]  cycles_freq_out;
  logic              ramp_done;
  logic              busy;
`ifdef PWM_DUTY_RAMP_DIV_EN
  logic [3:0]        ramp_div;
  initial ramp_div = 4'd0;
`endif

  pwm_duty_ramp #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_in        (start_in),
    .cycles_high_tgt (cycles_high_tgt),
    .cycles_freq_tgt (cycles_freq_tgt),
    .step            (step),
`ifdef PWM_DUTY_RAMP_DIV_EN
    .ramp_div        (ramp_div),
`endif
    .start_out       (start_out),
    .cycles_high_out (cycles_high_out),
    .cycles_freq_out (cycles_freq_out),
    .ramp_done       (ramp_done),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks   = 0;
  int n_failures = 0;
  bit mon_en     = 1'b0;

  typedef struct {
    int cyc;
    int start;
    int high;
    int freq;
    int done;
    int busy;
  } ev_t;

  ev_t sb[$];

  // Reference model state, expressed as phases and absolute boundary times.
  localparam int PH_IDLE = 0;
  localparam int PH_UP   = 1;
  localparam int PH_HOLD = 2;
  localparam int PH_DOWN = 3;

  int  m_phase = PH_IDLE;
  int  m_run   = 0;
  int  m_high  = 0;
  int  m_freq  = 0;
  int  m_done  = 0;
  int  m_next  = 0;
  ev_t m_last  = '{0, 0, 0, 0, 0, 0};

  function automatic int len_of(int f);
    return (f > 1) ? f : 1;
  endfunction

  // Advance the model across the clock edge at cycle p with the given inputs.
  function automatic void model_step(int p, int s, int h, int f, int st);
    int  tgt;
    bit  pe;
    int  old;
    ev_t e;
    tgt    = (h < f) ? h : f;
    pe     = (m_run != 0) && (p == m_next);
    m_done = 0;
    case (m_phase)
      PH_IDLE: begin
        if (s != 0) begin
          m_freq  = f;
          m_high  = 0;
          m_run   = 1;
          m_phase = PH_UP;
          m_next  = p + len_of(f);
        end
      end
      PH_UP: begin
        if (pe) begin
          m_high = (st == 0) ? tgt : ((m_high + st < tgt) ? m_high + st : tgt);
          m_next = p + len_of(m_freq);
          if (m_high == tgt) begin
            m_done  = 1;
            m_phase = PH_HOLD;
          end
        end
        if (s == 0) m_phase = PH_DOWN;
      end
      PH_HOLD: begin
        if (pe) begin
          m_freq = f;
          old    = m_high;
          if (m_high < tgt)      m_high = (st == 0) ? tgt : ((m_high + st < tgt) ? m_high + st : tgt);
          else if (m_high > tgt) m_high = (st == 0) ? tgt : ((m_high - st > tgt) ? m_high - st : tgt);
          m_next = p + len_of(m_freq);
          if (m_high == tgt && old != tgt) m_done = 1;
        end
        if (s == 0) m_phase = PH_DOWN;
      end
      default: begin
        if (pe) begin
          m_high = (st != 0 && m_high > st) ? m_high - st : 0;
          m_next = p + len_of(m_freq);
          if (m_high == 0) begin
            m_run   = 0;
            m_phase = PH_IDLE;
          end
        end
        if (s != 0) begin
          m_run   = 1;
          m_phase = PH_UP;
        end
      end
    endcase
    e = '{p, m_run, m_high, m_freq, m_done, (m_phase != PH_IDLE) ? 1 : 0};
    if (e.start != m_last.start || e.high != m_last.high || e.freq != m_last.freq ||
        e.done != m_last.done || e.busy != m_last.busy) begin
      sb.push_back(e);
    end
    m_last = e;
  endfunction

  // Apply one input setting for n clock edges, feeding the model each edge.
  task automatic drive(input int n, input int s, input int h, input int f, input int st);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start_in        = (s != 0);
      cycles_high_tgt = WIDTH'(h);
      cycles_freq_tgt = WIDTH'(f);
      step            = STEP_W'(st);
      model_step(cyc + 1, s, h, f, st);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: each change of the DUT output tuple must match the next prediction.
  initial begin
    ev_t prev;
    ev_t cur;
    ev_t e;
    prev = '{0, 0, 0, 0, 0, 0};
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur = '{cyc, int'(start_out), int'(cycles_high_out), int'(cycles_freq_out),
                int'(ramp_done), int'(busy)};
        if (cur.start != prev.start || cur.high != prev.high || cur.freq != prev.freq ||
            cur.done != prev.done || cur.busy != prev.busy) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_failures++;
            $display("FAIL unexpected_change cyc=%0d start=%0d high=%0d freq=%0d done=%0d busy=%0d, expected no change",
                     cur.cyc, cur.start, cur.high, cur.freq, cur.done, cur.busy);
          end else begin
            e = sb.pop_front();
            if (e.cyc != cur.cyc || e.start != cur.start || e.high != cur.high ||
                e.freq != cur.freq || e.done != cur.done || e.busy != cur.busy) begin
              n_failures++;
              $display("FAIL output_change got cyc=%0d start=%0d high=%0d freq=%0d done=%0d busy=%0d expected cyc=%0d start=%0d high=%0d freq=%0d done=%0d busy=%0d",
                       cur.cyc, cur.start, cur.high, cur.freq, cur.done, cur.busy,
                       e.cyc, e.start, e.high, e.freq, e.done, e.busy);
            end
          end
        end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
          n_checks++;
          n_failures++;
          e = sb.pop_front();
          $display("FAIL missing_change cyc=%0d got high=%0d start=%0d done=%0d, expected high=%0d start=%0d done=%0d",
                   cyc, cur.high, cur.start, cur.done, e.high, e.start, e.done);
        end
        prev = cur;
      end
    end
  end

  initial begin
    int guard;
    rst_n           = 1'b0;
    start_in        = 1'b0;
    cycles_high_tgt = '0;
    cycles_freq_tgt = '0;
    step            = '0;
    repeat (3) @(negedge clk);
    chk("reset_start_out", int'(start_out), 0);
    chk("reset_high", int'(cycles_high_out), 0);
    chk("reset_freq", int'(cycles_freq_out), 0);
    chk("reset_done_busy", int'({ramp_done, busy}), 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Soft start 0 -> 100 in steps of 25, period 400.
    drive(2000, 1, 100, 400, 25);
    chk("ramp_up_high", int'(cycles_high_out), 100);
    chk("ramp_up_freq", int'(cycles_freq_out), 400);
    chk("ramp_up_busy", int'(busy), 1);

    // Soft stop back to zero.
    drive(2000, 0, 100, 400, 25);
    chk("ramp_down_start_out", int'(start_out), 0);
    chk("ramp_down_busy", int'(busy), 0);
    chk("ramp_down_high", int'(cycles_high_out), 0);

    // Zero step with a target above the period clamps to the period.
    drive(400, 1, 300, 200, 0);
    chk("clamp_high", int'(cycles_high_out), 200);

    // Retarget while tracking: new period at the boundary, then step down.
    drive(2500, 1, 40, 100, 10);
    chk("retarget_high", int'(cycles_high_out), 40);
    chk("retarget_freq", int'(cycles_freq_out), 100);

    // Climb back to 100, drop the request until 50, then resume upward.
    drive(2000, 1, 100, 400, 25);
    chk("climb_high", int'(cycles_high_out), 100);
    guard = 0;
    while (m_high != 50 && guard < 3000) begin
      drive(1, 0, 100, 400, 25);
      guard++;
    end
    chk("reach_50_in_budget", (guard < 3000) ? 1 : 0, 1);
    drive(1200, 1, 100, 400, 25);
    chk("resume_high", int'(cycles_high_out), 100);
    chk("resume_busy", int'(busy), 1);

    // Randomized segments with small periods so boundaries are frequent.
    for (int seg = 0; seg < 250; seg++) begin
      drive($urandom_range(1, 150), ($urandom_range(0, 3) != 0) ? 1 : 0,
            $urandom_range(0, 60), $urandom_range(0, 40), $urandom_range(0, 12));
    end

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("scoreboard_drained", sb.size(), 0);

    // Asynchronous reset while running.
    start_in        = 1'b1;
    cycles_high_tgt = WIDTH'(100);
    cycles_freq_tgt = WIDTH'(50);
    step            = STEP_W'(5);
    repeat (4) @(posedge clk);
    #1;
    chk("running_before_reset", int'(start_out), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_start_out", int'(start_out), 0);
    chk("async_reset_high", int'(cycles_high_out), 0);
    chk("async_reset_freq", int'(cycles_freq_out), 0);
    chk("async_reset_done_busy", int'({ramp_done, busy}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule

// File: doc/pwm_duty_ramp.md
Name: pwm_duty_ramp

Overview:
Soft-start / soft-stop stage between the SPI-written device register file and the PWM generator. Accepts target high-time and period values, then forwards them to the generator. The forwarded high-time slews toward the target by a programmable step once per PWM period. All parameter changes take effect only at period boundaries, so the generator never sees a mid-period glitch.

Parameters:
WIDTH, 16, width of cycle counts (high-time and period)
STEP_W, 8, width of the per-period step input

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
start_in  in  1  run request (ctrl reg bit 0 OR external start)
cycles_high_tgt  in  WIDTH  target high-time in clk cycles
cycles_freq_tgt  in  WIDTH  target period in clk cycles
step  in  STEP_W  high-time increment/decrement per period; 0 = no ramp
start_out  out  1  start to PWM generator
cycles_high_out  out  WIDTH  current high-time to PWM generator
cycles_freq_out  out  WIDTH  current period to PWM generator
ramp_done  out  1  one-cycle pulse when the active high-time first equals its target
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: state IDLE, start_out=0, cycles_high_out=0, cycles_freq_out=0, ramp_done=0, busy=0, period counter=0.
- Period counter: runs only while start_out=1.
  - Counts 0 .. cycles_freq_out-1, then wraps to 0.
  - period_end = (cnt == cycles_freq_out-1).
  - cycles_freq_out of 0 or 1 gives period_end on every cycle.
- Effective target: tgt = min(cycles_high_tgt, cycles_freq_tgt). The high-time never exceeds the period.
- Slew arithmetic:
  - Computed in WIDTH+1 bits.
  - Up: min(cur+step, tgt).
  - Down: cur-step saturated at max(tgt,0).
  - step=0 means jump straight to the target.
- IDLE:
  - start_in=1 (level) → cycles_freq_out ← cycles_freq_tgt, cycles_high_out ← 0, start_out ← 1, cnt ← 0, go to RAMP_UP.
  - All outputs are registered; start_out rises 1 cycle after start_in.
- RAMP_UP:
  - On period_end, apply the up-slew.
  - If the result equals tgt: pulse ramp_done in the same cycle the value updates, then go to TRACK.
  - If tgt is 0 on entry: go to TRACK on the first period_end with ramp_done.
  - start_in=0 → RAMP_DOWN. This is evaluated every cycle, and the transition is immediate.
- TRACK:
  - On period_end, latch cycles_freq_out ← cycles_freq_tgt.
  - On the same period_end, slew cycles_high_out toward the new tgt, in either direction, by step.
  - ramp_done pulses again whenever the value newly reaches the target after having differed.
  - start_in=0 → RAMP_DOWN.
- RAMP_DOWN:
  - On period_end, cycles_high_out ← max(cur-step, 0); step=0 means immediately 0.
  - When cycles_high_out==0 at a period_end: start_out ← 0, cnt ← 0, go to IDLE.
  - start_in=1 → RAMP_UP, resuming from the current cycles_high_out. There is no reset to 0.
- Simultaneous events:
  - A start_in change on a period_end cycle: the state transition wins.
  - The slew for that period_end is still applied using the old state's direction.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous); start_out drops without ramp-down.
- Period reload happens only at period_end in TRACK and on entry from IDLE. A target change during RAMP_UP/RAMP_DOWN is applied at the next boundary while in TRACK.

Optional Feature:
Macro PWM_DUTY_RAMP_DIV_EN.
- Defined:
  - Adds input ramp_div [3:0] and an internal 16-bit period-count prescaler.
  - Slew steps occur only on every 2^ramp_div-th period_end.
  - The prescaler clears on entry to RAMP_UP and RAMP_DOWN.
  - Period reload in TRACK still happens on every period_end.
- Undefined: the port is absent; a step occurs on every period_end.

Test Plan:
1. Reset, then start_in=1 with tgt high=100, freq=400, step=25 → start_out=1 after 1 clk. cycles_high_out goes 0→25→50→75→100 at successive period ends (every 400 clks). ramp_done pulses once at 100; state is TRACK.
2. From TRACK at 100, drop start_in → high-time goes 75,50,25,0 at period ends; start_out=0 at the period_end where the value hits 0; busy=0.
3. step=0, tgt high=300, freq=200 → clamp: cycles_high_out=200 at the first period_end, ramp_done pulses.
4. In TRACK, change tgt high to 40 and freq to 100 mid-period → no output change until period_end. Then freq_out=100 and high steps down by step per period to 40, with a ramp_done pulse.
5. During RAMP_DOWN at high=50, reassert start_in → RAMP_UP continues 75,100 with no drop to 0.
6. Assert rst_n=0 mid-RAMP_UP → all outputs 0 asynchronously. With PWM_DUTY_RAMP_DIV_EN and ramp_div=2, steps occur every 4 periods.
